// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo frame scheduler.
// Holds the link state encoding, parameter defaults, datapath widths and the position clamp.
package servo_pkg;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_t;

  localparam int CLK_DIV_DEF        = 100;
  localparam int FRAME_TICKS_DEF    = 3000;
  localparam int OFFSET_DEF         = 1000;
  localparam int POS_MAX_DEF        = 1000;
  localparam int CENTER_DEF         = 500;
  localparam int TIMEOUT_FRAMES_DEF = 16;

  localparam int CNT_W = 12;
  localparam int POS_W = 10;
  localparam int THR_W = 11;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing the shared tick: high for one clk out of every CLK_DIV.
module servo_tick_gen
  import servo_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (tick) pre_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/servo_frame_ctrl.sv
// Frame counter, SPI position staging and frame-aligned threshold commit for two servo axes.
// A link FSM returns both thresholds to centre when commits stop arriving.
module servo_frame_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_DIV        = CLK_DIV_DEF,
  parameter int FRAME_TICKS    = FRAME_TICKS_DEF,
  parameter int OFFSET         = OFFSET_DEF,
  parameter int POS_MAX        = POS_MAX_DEF,
  parameter int CENTER         = CENTER_DEF,
  parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_valid,
  input  logic [POS_W-1:0] spi_x,
  input  logic [POS_W-1:0] spi_y,
  output logic             spi_ready,
  output logic [CNT_W-1:0] cntr_val,
  output logic [THR_W-1:0] x_val,
  output logic [THR_W-1:0] y_val,
  output logic             frame_start,
  output logic             link_ok
);

  // state     | meaning
  // LINK_DOWN | no recent commits; thresholds parked at centre
  // LINK_UP   | commits arriving; thresholds follow SPI positions

  localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [THR_W-1:0] CENTER_THR = THR_W'(CENTER + OFFSET);
  localparam logic [THR_W-1:0] OFFSET_THR = THR_W'(OFFSET);
  localparam logic [POS_W-1:0] POS_LIMIT  = POS_W'(POS_MAX);

  logic tick, wrap, accept, commit;

  link_state_t      state_q, state_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic [THR_W-1:0] x_q, x_d, y_q, y_d;
  logic [POS_W-1:0] stage_x_q, stage_x_d, stage_y_q, stage_y_d;
  logic             pending_q, pending_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic             frame_start_q;

  servo_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap      = tick && (cntr_q == FRAME_LAST);
  // The stage frees up on the wrap cycle itself, so a stalled sender lands in the next frame.
  assign spi_ready = !pending_q || wrap;
  assign accept    = spi_valid && spi_ready;
  assign commit    = wrap && pending_q;

  assign cntr_val    = cntr_q;
  assign x_val       = x_q;
  assign y_val       = y_q;
  assign frame_start = frame_start_q;
  assign link_ok     = (state_q == LINK_UP);

  always_comb begin
    cntr_d = cntr_q;
    if (tick) cntr_d = wrap ? '0 : cntr_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    stage_x_d = stage_x_q;
    stage_y_d = stage_y_q;
    pending_d = pending_q;
    miss_d    = miss_q;

    if (commit) begin
      x_d       = {1'b0, stage_x_q} + OFFSET_THR;
      y_d       = {1'b0, stage_y_q} + OFFSET_THR;
      miss_d    = '0;
      pending_d = 1'b0;
      state_d   = LINK_UP;
    end else if (wrap) begin
      if (int'(miss_q) < TIMEOUT_FRAMES) miss_d = miss_q + 1'b1;
      case (state_q)
        LINK_UP: begin
          if (int'(miss_q) + 1 == TIMEOUT_FRAMES) begin
            state_d = LINK_DOWN;
            x_d     = CENTER_THR;
            y_d     = CENTER_THR;
          end
        end
        default: begin
          x_d = CENTER_THR;
          y_d = CENTER_THR;
        end
      endcase
    end

    // Written after the commit branch so a same-cycle accept keeps pending set.
    if (accept) begin
      stage_x_d = clamp_pos(spi_x, POS_LIMIT);
      stage_y_d = clamp_pos(spi_y, POS_LIMIT);
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LINK_DOWN;
      cntr_q        <= '0;
      x_q           <= CENTER_THR;
      y_q           <= CENTER_THR;
      stage_x_q     <= '0;
      stage_y_q     <= '0;
      pending_q     <= 1'b0;
      miss_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cntr_q        <= cntr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      stage_x_q     <= stage_x_d;
      stage_y_q     <= stage_y_d;
      pending_q     <= pending_d;
      miss_q        <= miss_d;
      frame_start_q <= wrap;
    end
  end

endmodule
